// File: rtl/isp_frame_sched.sv
// Frame scheduler: queues read-DMA frame descriptors and launches
// them one at a time, with done/timeout tracking and completion irq.
// Ports: hclk/n_hreset; sched_en; desc_* push side (full, level);
//   to_limit; isp_raddr/hsize/vsize/start to the DMA, isp_done
//   back; busy, frame_cnt, irq, to_err status.
module isp_frame_sched #(
  parameter int DEPTH = 4,
  parameter int TO_W  = 24
) (
  input  logic                     hclk,
  input  logic                     n_hreset,
  input  logic                     sched_en,
  input  logic                     desc_push,
  input  logic [31:0]              desc_raddr,
  input  logic [15:0]              desc_hsize,
  input  logic [15:0]              desc_vsize,
  output logic                     desc_full,
  output logic [$clog2(DEPTH):0]   desc_level,
  input  logic [TO_W-1:0]          to_limit,
  output logic [31:0]              isp_raddr,
  output logic [31:0]              isp_hsize,
  output logic [31:0]              isp_vsize,
  output logic [31:0]              isp_start,
  input  logic                     isp_done,
  output logic                     busy,
  output logic [15:0]              frame_cnt,
  output logic                     irq,
  output logic                     to_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    GAP
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   mem_addr [DEPTH];
  logic [15:0]   mem_h    [DEPTH];
  logic [15:0]   mem_v    [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;

  logic          en_q;
  logic          en_rise;
  logic          err_blk;
  logic          head_ok;
  logic          pop;
  logic          load;
  logic          push_ok;
  logic          done_hit;
  logic          to_evt;
  logic          to_hit;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W:0]   cnt_inc;

  assign desc_full  = (level == LW'(DEPTH));
  assign desc_level = level;
  assign busy       = (state != IDLE);
  assign isp_start  = {31'd0, state == START};

  // A fresh enable clears the sticky error in the same cycle it is
  // seen, so the launch check must not be blocked by the stale flag.
  assign en_rise = sched_en & ~en_q;
  assign err_blk = to_err & ~en_rise;

  assign head_ok = (|mem_h[rptr]) && (|mem_v[rptr]);
  assign push_ok = desc_push && (!desc_full || pop);

  // Counter value after this cycle's increment, compared
  // against the limit so to_err rises as it reaches to_limit.
  assign cnt_inc = {1'b0, to_cnt} + (TO_W+1)'(1);
  assign to_hit  = (to_limit != '0) &&
                   (cnt_inc >= {1'b0, to_limit});

  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    done_hit  = 1'b0;
    to_evt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sched_en && level != '0 && !err_blk) begin
          pop = 1'b1;
          if (head_ok) begin
            load      = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD:  state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (isp_done) begin
          done_hit  = 1'b1;
          state_nxt = GAP;
        end else if (to_hit) begin
          to_evt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (push_ok) begin
      mem_addr[wptr] <= desc_raddr;
      mem_h[wptr]    <= desc_hsize;
      mem_v[wptr]    <= desc_vsize;
    end
  end

  always_ff @(posedge hclk or negedge n_hreset) begin
    if (!n_hreset) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      en_q      <= 1'b0;
      irq       <= 1'b0;
      to_err    <= 1'b0;
      frame_cnt <= '0;
      to_cnt    <= '0;
      isp_raddr <= '0;
      isp_hsize <= '0;
      isp_vsize <= '0;
    end else begin
      en_q <= sched_en;
      irq  <= done_hit | to_evt;
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (done_hit) frame_cnt <= frame_cnt + 16'd1;
      if (to_evt)       to_err <= 1'b1;
      else if (en_rise) to_err <= 1'b0;
      if (load) begin
        isp_raddr <= mem_addr[rptr];
        isp_hsize <= {16'd0, mem_h[rptr]};
        isp_vsize <= {16'd0, mem_v[rptr]};
      end
      if (state == LOAD)
        to_cnt <= '0;
      else if (state == START || state == WAIT)
        to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_isp_frame_sched.sv
// Bench for isp_frame_sched: scoreboard of expected starts and irqs
// checked by a negedge monitor; DMA responder answers each start.
module tb_isp_frame_sched;

  localparam int DEPTH = 4;
  localparam int TO_W  = 24;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            hclk = 1'b0;
  logic            n_hreset = 1'b0;
  logic            sched_en = 1'b0;
  logic            desc_push = 1'b0;
  logic [31:0]     desc_raddr = '0;
  logic [15:0]     desc_hsize = '0;
  logic [15:0]     desc_vsize = '0;
  logic            desc_full;
  logic [LW-1:0]   desc_level;
  logic [TO_W-1:0] to_limit = '0;
  logic [31:0]     isp_raddr, isp_hsize, isp_vsize, isp_start;
  logic            isp_done = 1'b0;
  logic            busy;
  logic [15:0]     frame_cnt;
  logic            irq;
  logic            to_err;

  isp_frame_sched #(.DEPTH(DEPTH), .TO_W(TO_W)) dut (
    .hclk(hclk), .n_hreset(n_hreset), .sched_en(sched_en),
    .desc_push(desc_push), .desc_raddr(desc_raddr),
    .desc_hsize(desc_hsize), .desc_vsize(desc_vsize),
    .desc_full(desc_full), .desc_level(desc_level),
    .to_limit(to_limit), .isp_raddr(isp_raddr),
    .isp_hsize(isp_hsize), .isp_vsize(isp_vsize),
    .isp_start(isp_start), .isp_done(isp_done), .busy(busy),
    .frame_cnt(frame_cnt), .irq(irq), .to_err(to_err)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] h;
    logic [15:0] v;
    int          skip;
  } st_t;

  typedef struct {
    bit is_to;
    int at;
    int cnt;
  } irq_t;

  st_t  start_q[$];
  irq_t irq_q[$];

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int stim_exp = -1, stim_at = 0;
  int resp_exp = -1, resp_at = 0;
  int exp_frames = 0;
  int n_starts = 0;
  int cd = 0;
  int delay_fix = 0;
  int skip_acc = 0;
  int stray_req = 0, stray_ack = 0;
  bit respond = 1'b1;
  bit en_model = 1'b0;

  always @(posedge hclk) cyc++;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                  nm, act, exp, cyc);
  endfunction

  // DMA responder + output monitor
  always @(negedge hclk) begin : env
    st_t  e;
    irq_t r;
    int   ex;
    if (!n_hreset) begin
      isp_done = 1'b0;
      cd = 0;
      exp_frames = 0;
      resp_exp = -1;
      stray_ack = stray_req;
      start_q.delete();
      irq_q.delete();
    end else begin
      isp_done = 1'b0;
      if (cd != 0) begin
        cd--;
        if (cd == 0) begin
          isp_done = 1'b1;
          exp_frames++;
          irq_q.push_back('{1'b0, cyc + 1, exp_frames});
          resp_at = cyc;
          if (en_model && start_q.size() != 0)
            resp_exp = cyc + 4 + start_q[0].skip;
          else
            resp_exp = -1;
        end
      end else if (stray_ack != stray_req) begin
        isp_done = 1'b1;
        stray_ack++;
      end
      if (isp_start != 0) begin
        chk("start_value", isp_start, 1);
        chk("start_busy", busy, 1);
        chk("start_expected", start_q.size() != 0, 1);
        if (start_q.size() != 0) begin
          e = start_q.pop_front();
          chk("start_raddr", isp_raddr, e.addr);
          chk("start_hsize", isp_hsize, {16'd0, e.h});
          chk("start_vsize", isp_vsize, {16'd0, e.v});
          ex = (stim_at >= resp_at) ? stim_exp : resp_exp;
          if (ex >= 0) chk("start_cycle", cyc, ex);
          n_starts++;
          if (respond)
            cd = (delay_fix != 0) ? delay_fix
                                  : int'($urandom_range(1, 20));
          else if (to_limit != 0)
            irq_q.push_back('{1'b1, cyc + int'(to_limit),
                              exp_frames});
        end
      end
      if (irq) begin
        chk("irq_expected", irq_q.size() != 0, 1);
        if (irq_q.size() != 0) begin
          r = irq_q.pop_front();
          chk("irq_cycle", cyc, r.at);
          chk("irq_frame_cnt", frame_cnt, r.cnt);
          chk("irq_to_err", to_err, r.is_to);
        end
      end
    end
  end

  task automatic step();
    @(negedge hclk);
    #1;
  endtask

  task automatic push_desc(input logic [31:0] a,
                           input logic [15:0] h,
                           input logic [15:0] v,
                           input bit acc);
    desc_raddr = a;
    desc_hsize = h;
    desc_vsize = v;
    desc_push  = 1'b1;
    if (acc) begin
      if (h != 0 && v != 0) begin
        start_q.push_back('{a, h, v, skip_acc});
        skip_acc = 0;
      end else begin
        skip_acc++;
      end
    end
    step();
    desc_push = 1'b0;
  endtask

  task automatic push_rand();
    push_desc($urandom & 32'hFFFF_FFFC,
              16'($urandom_range(1, 65535)),
              16'($urandom_range(1, 65535)), 1'b1);
  endtask

  task automatic enable();
    sched_en = 1'b1;
    en_model = 1'b1;
    stim_exp = cyc + 2 +
               ((start_q.size() != 0) ? start_q[0].skip : 0);
    stim_at  = cyc;
  endtask

  task automatic disable_sched();
    sched_en = 1'b0;
    en_model = 1'b0;
    step();
  endtask

  task automatic wait_quiet(input bit all);
    int n = 0;
    while (n < 3000 &&
           (busy || isp_done || irq_q.size() != 0 ||
            (all && start_q.size() != 0))) begin
      step();
      n++;
    end
    chk("quiet_in_budget", n < 3000, 1);
  endtask

  task automatic wait_start(input int n0);
    int n = 0;
    while (n_starts == n0 && n < 2000) begin
      step();
      n++;
    end
    chk("start_seen", n_starts != n0, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_irq"}, irq, 0);
    chk({tag, "_to_err"}, to_err, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_raddr"}, isp_raddr, 0);
    chk({tag, "_hsize"}, isp_hsize, 0);
    chk({tag, "_vsize"}, isp_vsize, 0);
    chk({tag, "_start"}, isp_start, 0);
    chk({tag, "_full"}, desc_full, 0);
    chk({tag, "_level"}, desc_level, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not finish, %0d/%0d so far",
             passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n0;
    int frames;
    int nd;
    int vc;
    step();
    step();
    check_zero("reset");
    n_hreset = 1'b1;
    step();
    step();

    // stray done while idle is ignored
    stray_req++;
    repeat (4) step();
    chk("stray_done_cnt", frame_cnt, 0);
    chk("stray_done_busy", busy, 0);

    // single frame pushed while enabled
    respond = 1'b1;
    enable();
    step();
    stim_exp = cyc + 3;
    stim_at  = cyc;
    push_desc(32'h0000_1000, 16'd4, 16'd2, 1'b1);
    wait_quiet(1'b1);
    chk("single_frame_cnt", frame_cnt, 1);
    chk("single_hold_raddr", isp_raddr, 32'h1000);
    chk("single_hold_hsize", isp_hsize, 4);

    // three frames back to back, done 10 cycles after start
    disable_sched();
    delay_fix = 10;
    repeat (3) push_rand();
    enable();
    wait_quiet(1'b1);
    chk("b2b_frame_cnt", frame_cnt, 4);
    chk("b2b_level", desc_level, 0);
    delay_fix = 0;

    // fill past full, then push and pop together at full
    disable_sched();
    for (int i = 0; i <= DEPTH; i++) begin
      push_desc($urandom & 32'hFFFF_FFFC, 16'd16, 16'd8,
                i < DEPTH);
      chk("fill_level", desc_level, (i < DEPTH) ? i + 1 : DEPTH);
    end
    chk("fill_full", desc_full, 1);
    desc_raddr = 32'h0000_ABC0;
    desc_hsize = 16'd3;
    desc_vsize = 16'd7;
    desc_push  = 1'b1;
    start_q.push_back('{32'h0000_ABC0, 16'd3, 16'd7, 0});
    enable();
    step();
    desc_push = 1'b0;
    chk("full_pushpop_level", desc_level, DEPTH);
    chk("full_pushpop_full", desc_full, 1);
    wait_quiet(1'b1);
    chk("drain_level", desc_level, 0);
    chk("drain_full", desc_full, 0);
    chk("drain_frame_cnt", frame_cnt, 4 + DEPTH + 1);
    frames = 4 + DEPTH + 1;

    // timeout blocks further launches until sched_en toggles
    disable_sched();
    to_limit = 50;
    respond = 1'b0;
    push_rand();
    push_rand();
    n0 = n_starts;
    enable();
    wait_start(n0);
    wait_quiet(1'b0);
    chk("to_err_set", to_err, 1);
    chk("to_frame_cnt", frame_cnt, frames);
    n0 = n_starts;
    repeat (20) step();
    chk("to_no_launch", n_starts, n0);
    chk("to_level", desc_level, 1);
    chk("to_err_sticky", to_err, 1);
    respond = 1'b1;
    disable_sched();
    enable();
    wait_quiet(1'b1);
    chk("to_err_cleared", to_err, 0);
    frames++;
    chk("to_resume_cnt", frame_cnt, frames);

    // zero-size descriptor is discarded
    disable_sched();
    push_desc(32'h0000_2000, 16'd0, 16'd5, 1'b1);
    push_desc(32'h0000_3000, 16'd8, 16'd1, 1'b1);
    enable();
    wait_quiet(1'b1);
    frames++;
    chk("zero_frame_cnt", frame_cnt, frames);
    chk("zero_raddr", isp_raddr, 32'h3000);
    chk("zero_level", desc_level, 0);

    // disabling mid-frame finishes the frame, no new launch
    disable_sched();
    push_rand();
    push_rand();
    n0 = n_starts;
    enable();
    wait_start(n0);
    sched_en = 1'b0;
    en_model = 1'b0;
    wait_quiet(1'b0);
    n0 = n_starts;
    repeat (10) step();
    frames++;
    chk("stop_no_launch", n_starts, n0);
    chk("stop_level", desc_level, 1);
    chk("stop_frame_cnt", frame_cnt, frames);
    enable();
    wait_quiet(1'b1);
    frames++;
    chk("stop_resume_cnt", frame_cnt, frames);

    // reset while waiting for done
    disable_sched();
    respond = 1'b0;
    to_limit = '0;
    push_rand();
    push_rand();
    n0 = n_starts;
    enable();
    wait_start(n0);
    push_rand();
    repeat (3) step();
    n_hreset = 1'b0;
    skip_acc = 0;
    step();
    check_zero("midrst");
    step();
    n_hreset = 1'b1;
    step();
    chk("postrst_level", desc_level, 0);
    chk("postrst_busy", busy, 0);
    respond = 1'b1;
    stim_exp = cyc + 3;
    stim_at  = cyc;
    push_rand();
    wait_quiet(1'b1);
    frames = 1;
    chk("postrst_frame_cnt", frame_cnt, frames);

    // randomized batches with some zero-size entries
    for (int it = 0; it < 8; it++) begin
      disable_sched();
      skip_acc = 0;
      to_limit = ($urandom_range(0, 1) != 0) ? TO_W'(200) : '0;
      nd = $urandom_range(1, DEPTH);
      vc = 0;
      for (int k = 0; k < nd; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          push_desc($urandom & 32'hFFFF_FFFC,
                    ($urandom_range(0, 1) != 0) ? 16'd0 : 16'd9,
                    16'd0, 1'b1);
        end else begin
          push_rand();
          vc++;
        end
      end
      enable();
      wait_quiet(1'b1);
      repeat (5) step();
      frames += vc;
      chk("rand_level", desc_level, 0);
      chk("rand_frame_cnt", frame_cnt, frames);
      chk("rand_to_err", to_err, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/isp_frame_sched.md
ISP_FRAME_SCHED -- requirements
Module: isp_frame_sched

Interface
REQ-001 Parameter DEPTH, default 4, descriptor FIFO depth (power of 2, 2..16).
REQ-002 Parameter TO_W, default 24, width of timeout counter and limit.
REQ-003 hclk  in  1  clock; all logic on rising edge.
REQ-004 n_hreset  in  1  reset, asynchronous, active-low.
REQ-005 sched_en  in  1  level; 1 = launch frames from FIFO.
REQ-006 desc_push  in  1  write one descriptor when desc_full=0.
REQ-007 desc_raddr  in  32  frame base address (word-aligned).
REQ-008 desc_hsize  in  16  words per line.
REQ-009 desc_vsize  in  16  lines per frame.
REQ-010 desc_full  out  1  FIFO holds DEPTH entries.
REQ-011 desc_level  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-012 to_limit  in  TO_W  max cycles to wait for isp_done; 0 disables timeout.
REQ-013 isp_raddr, isp_hsize, isp_vsize  out  32 each  frame config to the read-DMA, zero-extended.
REQ-014 isp_start  out  32  start pulse to the read-DMA; value 1 or 0 only.
REQ-015 isp_done  in  1  one-cycle frame-complete pulse from the read-DMA.
REQ-016 busy  out  1  frame in flight (states LOAD..GAP).
REQ-017 frame_cnt  out  16  completed frames, wraps 0xFFFF->0.
REQ-018 irq  out  1  one-cycle pulse on completion or timeout.
REQ-019 to_err  out  1  sticky timeout flag; cleared by sched_en 0->1.

Function
REQ-020 FIFO: push with full is dropped, with no state change; simultaneous push and pop when full is allowed, and level stays unchanged.
REQ-021 FSM states: IDLE, LOAD, START, WAIT, GAP.
REQ-022 IDLE->LOAD when sched_en=1, level>0 and to_err=0; pops the head into the output config registers.
REQ-023 LOAD->START after 1 cycle; config outputs are stable at least 1 cycle before start.
REQ-024 START: isp_start=1 for exactly this one cycle, then go to WAIT.
REQ-025 WAIT: timeout counter increments each cycle.
REQ-026 WAIT, on isp_done=1: frame_cnt+1, irq pulse, go to GAP.
REQ-027 WAIT, when to_limit!=0 and the counter reaches to_limit with no isp_done: to_err=1, irq pulse, go to IDLE, descriptor discarded.
REQ-028 GAP: 1 cycle with isp_start=0 (the DMA clears done in its idle state), then IDLE.
REQ-029 Launch latency: FIFO non-empty in IDLE -> isp_start high 2 cycles later.
REQ-030 Back-to-back frames: isp_done cycle N -> next isp_start at N+4 (GAP, IDLE, LOAD, START).
REQ-031 isp_done outside WAIT is ignored.
REQ-032 Config outputs hold their last value until the next LOAD.
REQ-033 sched_en=0 mid-frame does not abort; the current frame completes and no new LOAD occurs.
REQ-034 Descriptors with hsize=0 or vsize=0 are popped and discarded in IDLE; no start is issued and frame_cnt is unchanged.

Reset
REQ-035 During n_hreset=0: state IDLE; FIFO empty; all outputs 0; desc_full=0; desc_level=0.
REQ-036 Reset mid-frame discards FIFO contents and the in-flight frame; no irq is produced.

Verification
REQ-037 Push {0x1000,4,2} with sched_en=1 -> isp_start=1 for 1 cycle with isp_raddr=0x1000, isp_hsize=4, isp_vsize=2; done pulse -> irq, frame_cnt=1.
REQ-038 Push 3 descriptors, return done 10 cycles after each start -> 3 starts, each 4 cycles after the prior done; frame_cnt=3; level=0.
REQ-039 Push DEPTH+1 descriptors while sched_en=0 -> desc_full=1, level=DEPTH, extra push dropped.
REQ-040 to_limit=50, done never returned -> to_err=1 and irq 50 cycles after start; next descriptor not launched until sched_en toggles.
REQ-041 Push {0x2000,0,5} then {0x3000,8,1} -> only 0x3000 launched; frame_cnt=1.
REQ-042 Assert n_hreset during WAIT -> all outputs 0; a later push launches normally.
